// File: rtl/shared_bus_arb_pkg.sv
// Shared types and width helpers for the shared-bus arbiter.
// The helpers size the tenure and turnaround counters.
package shared_bus_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        TURN  = 2'd2
    } arb_state_e;

    // The tenure counter saturates at hold_max-1, so it needs to hold values 0..hold_max-1.
    function automatic int tenure_w(input int hold_max);
        return (hold_max > 2) ? $clog2(hold_max) : 1;
    endfunction

    // The turnaround counter holds values 0..turn_cyc-1. It is always at least 1 bit wide.
    function automatic int turn_w(input int turn_cyc);
        return (turn_cyc > 1) ? $clog2(turn_cyc) : 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker. It returns the first high request at or after start,
// wrapping modulo NREQ.
module rr_pick #(
    parameter int NREQ = 4,
    parameter int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDXW-1:0] start,
    output logic            valid,
    output logic [IDXW-1:0] win
);

    int k;

    // Walk the offsets from farthest to nearest, so that the nearest high request is
    // written last and wins.
    always_comb begin
        valid = |req;
        win   = '0;
        k     = 0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            k = int'(start) + i;
            if (k >= NREQ) begin
                k = k - NREQ;
            end
            if (req[IDXW'(k)]) begin
                win = IDXW'(k);
            end
        end
    end

endmodule

// File: rtl/shared_bus_arb.sv
// Round-robin owner arbiter for a shared tri-state bus. It enforces an undriven
// turnaround after every release and caps the tenure of an unlocked owner.
module shared_bus_arb
    import shared_bus_arb_pkg::*;
#(
    parameter int NREQ     = 4,
    parameter int HOLD_MAX = 8,
    parameter int TURN_CYC = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ-1:0]         lock,
    output logic [NREQ-1:0]         gnt,
    output logic                    bus_oe,
    output logic [$clog2(NREQ)-1:0] owner,
    output logic                    busy,
    output logic [1:0]              state
);

    localparam int IDXW = $clog2(NREQ);
    localparam int TW   = tenure_w(HOLD_MAX);
    localparam int CW   = turn_w(TURN_CYC);

    localparam logic [1:0] S_IDLE  = 2'(IDLE);
    localparam logic [1:0] S_GRANT = 2'(GRANT);
    localparam logic [1:0] S_TURN  = 2'(TURN);

    localparam logic [TW-1:0] TEN_MAX   = TW'(HOLD_MAX - 1);
    localparam logic [CW-1:0] TURN_LAST = CW'(TURN_CYC - 1);

    logic [1:0]      state_q;
    logic [TW-1:0]   tenure_q;
    logic [CW-1:0]   turn_q;
    logic [NREQ-1:0] gnt_q;
    logic            oe_q;
    logic [IDXW-1:0] owner_q;

    logic [IDXW-1:0] start_idx;
    logic [IDXW-1:0] win_idx;
    logic            win_valid;
    logic [NREQ-1:0] win_vec;
    logic            others;
    logic            release_c;
    logic            preempt_c;

    // The previous owner is searched last, but it can still win.
    assign start_idx = (owner_q == IDXW'(NREQ - 1)) ? '0 : owner_q + IDXW'(1);

    rr_pick #(.NREQ(NREQ), .IDXW(IDXW)) u_pick (
        .req   (req),
        .start (start_idx),
        .valid (win_valid),
        .win   (win_idx)
    );

    assign win_vec   = NREQ'(1) << win_idx;
    assign others    = |(req & ~gnt_q);
    assign release_c = ~req[owner_q];
    assign preempt_c = (tenure_q == TEN_MAX) && others && ~lock[owner_q];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            tenure_q <= '0;
            turn_q   <= '0;
            gnt_q    <= '0;
            oe_q     <= 1'b0;
            owner_q  <= IDXW'(NREQ - 1);
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (win_valid) begin
                        state_q  <= S_GRANT;
                        gnt_q    <= win_vec;
                        oe_q     <= 1'b1;
                        owner_q  <= win_idx;
                        tenure_q <= '0;
                    end
                end
                S_GRANT: begin
                    // When release and preemption coincide, only one turnaround is taken.
                    if (release_c || preempt_c) begin
                        state_q <= S_TURN;
                        gnt_q   <= '0;
                        oe_q    <= 1'b0;
                        turn_q  <= '0;
                    end else if (tenure_q != TEN_MAX) begin
                        tenure_q <= tenure_q + TW'(1);
                    end
                end
                S_TURN: begin
                    // Requests are sampled only on the last turnaround cycle.
                    if (turn_q == TURN_LAST) begin
                        if (win_valid) begin
                            state_q  <= S_GRANT;
                            gnt_q    <= win_vec;
                            oe_q     <= 1'b1;
                            owner_q  <= win_idx;
                            tenure_q <= '0;
                        end else begin
                            state_q <= S_IDLE;
                        end
                    end else begin
                        turn_q <= turn_q + CW'(1);
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    gnt_q   <= '0;
                    oe_q    <= 1'b0;
                end
            endcase
        end
    end

    assign gnt    = gnt_q;
    assign bus_oe = oe_q;
    assign owner  = owner_q;
    assign busy   = (state_q != S_IDLE);
    assign state  = state_q;

endmodule

// File: tb/tb_shared_bus_arb.sv
// Bench for shared_bus_arb. It uses a table of directed vectors, directed corner sequences,
// and randomized traffic. The traffic is checked every cycle against a reference model.
module tb_shared_bus_arb;
    import shared_bus_arb_pkg::*;

    localparam int N  = 4;
    localparam int HM = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] req_a = '0, lock_a = '0, req_b = '0, lock_b = '0;
    logic [3:0] gnt_a, gnt_b;
    logic       oe_a, oe_b, busy_a, busy_b;
    logic [1:0] own_a, own_b, st_a, st_b;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model, one slot per instance: 0 is TURN_CYC=1 and 1 is TURN_CYC=3.
    int m_active[2];
    int m_owner[2];
    int m_ten[2];
    int m_gap[2];
    int m_turn[2] = '{1, 3};

    typedef struct {
        logic [3:0] req;
        logic [3:0] gnt;
        logic       oe;
        logic       busy;
        logic [1:0] owner;
    } vec_t;
    vec_t tbl[14];

    shared_bus_arb #(.NREQ(4), .HOLD_MAX(8), .TURN_CYC(1)) dut (
        .clk(clk), .rst_n(rst_n), .req(req_a), .lock(lock_a), .gnt(gnt_a),
        .bus_oe(oe_a), .owner(own_a), .busy(busy_a), .state(st_a)
    );

    shared_bus_arb #(.NREQ(4), .HOLD_MAX(8), .TURN_CYC(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .req(req_b), .lock(lock_b), .gnt(gnt_b),
        .bus_oe(oe_b), .owner(own_b), .busy(busy_b), .state(st_b)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL global_timeout: time %0t reached without finishing", $time);
        $fatal(1, "bench timeout");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic int pick(input int last, input logic [3:0] r);
        for (int k = 1; k <= N; k++) begin
            int j;
            j = (last + k) % N;
            if (r[2'(j)]) return j;
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_active[i] = 0;
            m_owner[i]  = N - 1;
            m_ten[i]    = 0;
            m_gap[i]    = 0;
        end
    endtask

    task automatic model_step(input int i, input logic [3:0] r, input logic [3:0] l);
        int  w;
        logic give_up;
        if (m_active[i] != 0) begin
            give_up = !r[2'(m_owner[i])] ||
                      (m_ten[i] >= HM - 1 && (r & ~(4'b0001 << m_owner[i])) != 4'b0000 &&
                       !l[2'(m_owner[i])]);
            if (give_up) begin
                m_active[i] = 0;
                m_gap[i]    = m_turn[i];
            end else if (m_ten[i] < HM - 1) begin
                m_ten[i]++;
            end
        end else begin
            if (m_gap[i] > 0) m_gap[i]--;
            if (m_gap[i] == 0) begin
                w = pick(m_owner[i], r);
                if (w >= 0) begin
                    m_active[i] = 1;
                    m_owner[i]  = w;
                    m_ten[i]    = 0;
                end
            end
        end
    endtask

    task automatic check_inst(input string tag, input int i, input logic [3:0] g, input logic oe,
                              input logic bz, input logic [1:0] ow, input logic [1:0] st);
        logic [3:0] eg;
        logic [1:0] es;
        eg = (m_active[i] != 0) ? (4'b0001 << m_owner[i]) : 4'b0000;
        es = (m_active[i] != 0) ? 2'(GRANT) : ((m_gap[i] > 0) ? 2'(TURN) : 2'(IDLE));
        chk({tag, "_gnt"}, 32'(g), 32'(eg));
        chk({tag, "_oe"}, 32'(oe), 32'(m_active[i] != 0));
        chk({tag, "_busy"}, 32'(bz), 32'(m_active[i] != 0 || m_gap[i] > 0));
        chk({tag, "_owner"}, 32'(ow), 32'(m_owner[i]));
        chk({tag, "_state"}, 32'(st), 32'(es));
        chk({tag, "_onehot"}, 32'((g & (g - 4'd1)) == 4'd0), 32'd1);
        chk({tag, "_oe_vs_gnt"}, 32'(oe), 32'(|g));
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst_n) begin
            model_step(0, req_a, lock_a);
            model_step(1, req_b, lock_b);
        end
        @(negedge clk);
        check_inst("a", 0, gnt_a, oe_a, busy_a, own_a, st_a);
        check_inst("b", 1, gnt_b, oe_b, busy_b, own_b, st_b);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n  = 1'b0;
        req_a  = '0;
        lock_a = '0;
        req_b  = '0;
        lock_b = '0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [3:0] e;

        tbl[0]  = '{4'b0001, 4'b0001, 1'b1, 1'b1, 2'd0};
        tbl[1]  = '{4'b0000, 4'b0000, 1'b0, 1'b1, 2'd0};
        tbl[2]  = '{4'b0000, 4'b0000, 1'b0, 1'b0, 2'd0};
        tbl[3]  = '{4'b0110, 4'b0010, 1'b1, 1'b1, 2'd1};
        tbl[4]  = '{4'b0110, 4'b0010, 1'b1, 1'b1, 2'd1};
        tbl[5]  = '{4'b0100, 4'b0000, 1'b0, 1'b1, 2'd1};
        tbl[6]  = '{4'b0100, 4'b0100, 1'b1, 1'b1, 2'd2};
        tbl[7]  = '{4'b1100, 4'b0100, 1'b1, 1'b1, 2'd2};
        tbl[8]  = '{4'b1000, 4'b0000, 1'b0, 1'b1, 2'd2};
        tbl[9]  = '{4'b0001, 4'b0001, 1'b1, 1'b1, 2'd0};
        tbl[10] = '{4'b0000, 4'b0000, 1'b0, 1'b1, 2'd0};
        tbl[11] = '{4'b1001, 4'b1000, 1'b1, 1'b1, 2'd3};
        tbl[12] = '{4'b0000, 4'b0000, 1'b0, 1'b1, 2'd3};
        tbl[13] = '{4'b0000, 4'b0000, 1'b0, 1'b0, 2'd3};

        model_reset();
        repeat (2) @(negedge clk);
        chk("reset_gnt", 32'(gnt_a), 32'd0);
        chk("reset_oe", 32'(oe_a), 32'd0);
        chk("reset_busy", 32'(busy_a), 32'd0);
        chk("reset_owner", 32'(own_a), 32'd3);
        chk("reset_state", 32'(st_a), 32'(2'(IDLE)));
        rst_n = 1'b1;

        for (int i = 0; i < 14; i++) begin
            req_a = tbl[i].req;
            tick();
            chk($sformatf("tbl%0d_gnt", i), 32'(gnt_a), 32'(tbl[i].gnt));
            chk($sformatf("tbl%0d_oe", i), 32'(oe_a), 32'(tbl[i].oe));
            chk($sformatf("tbl%0d_busy", i), 32'(busy_a), 32'(tbl[i].busy));
            chk($sformatf("tbl%0d_owner", i), 32'(own_a), 32'(tbl[i].owner));
        end

        // Rotation with every requester active: 8-cycle tenures separated by one undriven cycle.
        req_a = 4'b1111;
        for (int c = 0; c < 40; c++) begin
            tick();
            e = ((c % 9) < 8) ? (4'b0001 << ((c / 9) % 4)) : 4'b0000;
            chk($sformatf("rot%0d_gnt", c), 32'(gnt_a), 32'(e));
        end

        // A locked owner keeps the bus past its tenure limit.
        do_reset();
        req_a = 4'b0100;
        tick();
        chk("lock_first_gnt", 32'(gnt_a), 32'(4'b0100));
        lock_a = 4'b0100;
        req_a  = 4'b0111;
        for (int c = 0; c < 20; c++) begin
            tick();
            chk($sformatf("lock%0d_gnt", c), 32'(gnt_a), 32'(4'b0100));
        end
        lock_a = 4'b0000;
        tick();
        chk("unlock_preempt_gnt", 32'(gnt_a), 32'(4'b0000));
        chk("unlock_preempt_busy", 32'(busy_a), 32'd1);
        tick();
        chk("unlock_next_gnt", 32'(gnt_a), 32'(4'b0001));

        // Three-cycle turnaround; requests that change before the last cycle are ignored.
        do_reset();
        req_b = 4'b0010;
        tick();
        chk("t3_grant1", 32'(gnt_b), 32'(4'b0010));
        req_b = 4'b1000;
        tick();
        chk("t3_turn1_oe", 32'(oe_b), 32'd0);
        req_b = 4'b0101;
        tick();
        chk("t3_turn2_oe", 32'(oe_b), 32'd0);
        req_b = 4'b0011;
        tick();
        chk("t3_turn3_oe", 32'(oe_b), 32'd0);
        req_b = 4'b1000;
        tick();
        chk("t3_grant3", 32'(gnt_b), 32'(4'b1000));
        chk("t3_owner3", 32'(own_b), 32'd3);

        // Asserting reset mid-grant drops the outputs without waiting for a clock edge.
        do_reset();
        req_a = 4'b0010;
        tick();
        chk("rst_mid_pre_gnt", 32'(gnt_a), 32'(4'b0010));
        tick();
        tick();
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_gnt", 32'(gnt_a), 32'd0);
        chk("rst_mid_oe", 32'(oe_a), 32'd0);
        chk("rst_mid_busy", 32'(busy_a), 32'd0);
        model_reset();
        req_a = 4'b0011;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("rst_after_gnt", 32'(gnt_a), 32'(4'b0001));
        chk("rst_after_owner", 32'(own_a), 32'd0);

        // Randomized traffic: each request bit is flipped occasionally so that tenures run long.
        do_reset();
        for (int c = 0; c < 500; c++) begin
            for (int b = 0; b < 4; b++) begin
                if ($urandom_range(0, 5) == 0) req_a[b] = ~req_a[b];
                if ($urandom_range(0, 5) == 0) req_b[b] = ~req_b[b];
                if ($urandom_range(0, 9) == 0) lock_a[b] = ~lock_a[b];
                if ($urandom_range(0, 9) == 0) lock_b[b] = ~lock_b[b];
            end
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
